// File: rtl/capture_sequencer.sv
// Capture/readout sequencer: turns one PS command into repeated sw-reset, arm/start/stop
// and readout-start config writes to the sample buffer, tracking depth and DMA completion.
module capture_sequencer #(
    parameter int COUNT_WIDTH   = 32,
    parameter int RESET_HOLD    = 4,
    parameter int DEPTH_TIMEOUT = 65536
) (
    input  logic                     ps_clk,
    input  logic                     ps_reset,
    input  logic [2*COUNT_WIDTH-1:0] cmd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     abort,
    output logic                     sw_reset_valid,
    input  logic                     sw_reset_ready,
    output logic [2:0]               ass_data,
    output logic                     ass_valid,
    input  logic                     ass_ready,
    output logic                     readout_start_valid,
    input  logic                     readout_start_ready,
    input  logic                     depth_valid,
    input  logic                     readout_last,
    output logic                     busy,
    output logic [COUNT_WIDTH-1:0]   captures_done,
    output logic                     error
);

    localparam int TMO_W  = $clog2(DEPTH_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int AUX_W  = (TMO_W > HOLD_W) ? TMO_W : HOLD_W;
    localparam int CNT_W  = (COUNT_WIDTH > AUX_W) ? COUNT_WIDTH : AUX_W;

    typedef enum logic [3:0] {
        IDLE, SW_RESET, HOLD, ARM, START, CAPTURE, STOP,
        WAIT_DEPTH, READOUT_START, READOUT, ABORT_RST
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] n_q, n_d, cyc_q, cyc_d;
    logic [COUNT_WIDTH-1:0] done_d, done_inc;
    logic                   err_d, pend_q, pend_d, abort_now;
    logic                   sw_xfer, ass_xfer, rs_xfer;

    function automatic logic [2:0] ass_code(input state_t s);
        case (s)
            ARM:     return 3'b100;
            START:   return 3'b010;
            STOP:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    assign sw_xfer  = sw_reset_valid && sw_reset_ready;
    assign ass_xfer = ass_valid && ass_ready;
    assign rs_xfer  = readout_start_valid && readout_start_ready;
    assign done_inc = captures_done + COUNT_WIDTH'(1);

    // Next-state: states holding a valid only leave on its transfer; a pending abort redirects that exit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        cyc_d     = cyc_q;
        done_d    = captures_done;
        err_d     = error;
        pend_d    = pend_q;
        abort_now = abort || pend_q;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    n_d    = cmd_data[2*COUNT_WIDTH-1:COUNT_WIDTH];
                    cyc_d  = cmd_data[COUNT_WIDTH-1:0];
                    done_d = '0;
                    err_d  = 1'b0;
                    if (cmd_data[2*COUNT_WIDTH-1:COUNT_WIDTH] != '0) state_d = SW_RESET;
                end
            end
            SW_RESET: begin
                if (sw_xfer) begin
                    if (abort_now) state_d = ABORT_RST;
                    else if (RESET_HOLD == 0) state_d = ARM;
                    else begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(RESET_HOLD);
                    end
                end else if (abort) pend_d = 1'b1;
            end
            HOLD: begin
                if (abort) state_d = ABORT_RST;
                else if (cnt_q <= CNT_W'(1)) state_d = ARM;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            ARM: begin
                if (ass_xfer) begin
                    if (abort_now) state_d = ABORT_RST;
                    else if (cyc_q != '0) state_d = START;
                    else begin
                        state_d = WAIT_DEPTH;
                        cnt_d   = CNT_W'(DEPTH_TIMEOUT);
                    end
                end else if (abort) pend_d = 1'b1;
            end
            START: begin
                if (ass_xfer) begin
                    if (abort_now) state_d = ABORT_RST;
                    else begin
                        state_d = CAPTURE;
                        cnt_d   = CNT_W'(cyc_q);
                    end
                end else if (abort) pend_d = 1'b1;
            end
            CAPTURE: begin
                if (abort) state_d = ABORT_RST;
                else if (cnt_q <= CNT_W'(1)) state_d = STOP;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            STOP: begin
                if (ass_xfer) begin
                    if (abort_now) state_d = ABORT_RST;
                    else begin
                        state_d = WAIT_DEPTH;
                        cnt_d   = CNT_W'(DEPTH_TIMEOUT);
                    end
                end else if (abort) pend_d = 1'b1;
            end
            WAIT_DEPTH: begin
                // depth_valid beats a timeout expiring in the same cycle
                if (abort) state_d = ABORT_RST;
                else if (depth_valid) state_d = READOUT_START;
                else if (cnt_q <= CNT_W'(1)) begin
                    err_d   = 1'b1;
                    state_d = ABORT_RST;
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            READOUT_START: begin
                if (rs_xfer) state_d = abort_now ? ABORT_RST : READOUT;
                else if (abort) pend_d = 1'b1;
            end
            READOUT: begin
                if (readout_last) begin
                    done_d = done_inc;
                    if (abort) state_d = ABORT_RST;
                    else if (done_inc == n_q) state_d = IDLE;
                    else state_d = SW_RESET;
                end else if (abort) state_d = ABORT_RST;
            end
            ABORT_RST: begin
                pend_d = 1'b0;
                if (sw_xfer) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and outputs: registered from next state so every valid is glitch-free and held.
    always_ff @(posedge ps_clk or posedge ps_reset) begin
        if (ps_reset) begin
            state_q             <= IDLE;
            pend_q              <= 1'b0;
            captures_done       <= '0;
            error               <= 1'b0;
            cmd_ready           <= 1'b1;
            busy                <= 1'b0;
            sw_reset_valid      <= 1'b0;
            ass_valid           <= 1'b0;
            ass_data            <= 3'b000;
            readout_start_valid <= 1'b0;
        end else begin
            state_q             <= state_d;
            pend_q              <= pend_d;
            captures_done       <= done_d;
            error               <= err_d;
            cmd_ready           <= (state_d == IDLE);
            busy                <= (state_d != IDLE);
            sw_reset_valid      <= (state_d == SW_RESET) || (state_d == ABORT_RST);
            ass_valid           <= (state_d == ARM) || (state_d == START) || (state_d == STOP);
            ass_data            <= ass_code(state_d);
            readout_start_valid <= (state_d == READOUT_START);
        end
    end

    // Datapath: command fields and the shared hold/duration/timeout counter
    always_ff @(posedge ps_clk) begin
        n_q   <= n_d;
        cyc_q <= cyc_d;
        cnt_q <= cnt_d;
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: scoreboard of expected config writes plus command table
// and hand-written stall, timeout, abort and reset sequences.
module tb_capture_sequencer;

    localparam int W   = 16;
    localparam int TMO = 16;

    logic             ps_clk = 1'b0;
    logic             ps_reset = 1'b1;
    logic [2*W-1:0]   cmd_data = '0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             abort = 1'b0;
    logic             sw_reset_valid;
    logic             sw_reset_ready = 1'b1;
    logic [2:0]       ass_data;
    logic             ass_valid;
    logic             ass_ready = 1'b1;
    logic             readout_start_valid;
    logic             readout_start_ready = 1'b1;
    logic             depth_valid = 1'b0;
    logic             readout_last = 1'b0;
    logic             busy;
    logic [W-1:0]     captures_done;
    logic             error;

    capture_sequencer #(.COUNT_WIDTH(W), .RESET_HOLD(4), .DEPTH_TIMEOUT(TMO)) dut (
        .ps_clk(ps_clk), .ps_reset(ps_reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .abort(abort),
        .sw_reset_valid(sw_reset_valid), .sw_reset_ready(sw_reset_ready),
        .ass_data(ass_data), .ass_valid(ass_valid), .ass_ready(ass_ready),
        .readout_start_valid(readout_start_valid), .readout_start_ready(readout_start_ready),
        .depth_valid(depth_valid), .readout_last(readout_last),
        .busy(busy), .captures_done(captures_done), .error(error)
    );

    always #5 ps_clk = ~ps_clk;

    typedef struct {
        int n;
        int cyc;
        int dly;
        int exp_done;
    } vec_t;

    vec_t vecs[5];
    int   exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   tick_n = 0;
    int   depth_dly = 0, last_dly = 0, depth_cd = 0, last_cd = 0;
    int   cur_cyc = 0;
    int   t_start = -1, t_stop = -1, t_rs = -1;
    bit   stop_gap_chk = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // write codes: 0 sw-reset, 1 arm, 2 start, 3 stop, 4 readout-start
    task automatic got(input int k);
        if (exp_q.size() == 0) chk("unexpected_write", k, 99);
        else chk("write_seq", k, exp_q.pop_front());
    endtask

    task automatic push_iter(input int cyc);
        exp_q.push_back(0);
        exp_q.push_back(1);
        if (cyc != 0) begin
            exp_q.push_back(2);
            exp_q.push_back(3);
        end
        exp_q.push_back(4);
    endtask

    task automatic tick();
        @(negedge ps_clk);
        if (!ps_reset) begin
            if (sw_reset_valid && sw_reset_ready) got(0);
            if (ass_valid && ass_ready) begin
                case (ass_data)
                    3'b100: begin
                        got(1);
                        if (cur_cyc == 0 && depth_dly > 0) depth_cd = depth_dly;
                    end
                    3'b010: begin
                        got(2);
                        t_start = tick_n;
                    end
                    3'b001: begin
                        got(3);
                        t_stop = tick_n;
                        if (stop_gap_chk) chk("stop_gap", tick_n - t_start, cur_cyc + 1);
                        if (depth_dly > 0) depth_cd = depth_dly;
                    end
                    default: got(7);
                endcase
            end
            if (readout_start_valid && readout_start_ready) begin
                got(4);
                t_rs = tick_n;
                if (last_dly > 0) last_cd = last_dly;
            end
        end
        @(posedge ps_clk);
        #1;
        tick_n++;
        depth_valid  = 1'b0;
        readout_last = 1'b0;
        if (depth_cd > 0) begin
            depth_cd--;
            if (depth_cd == 0) depth_valid = 1'b1;
        end
        if (last_cd > 0) begin
            last_cd--;
            if (last_cd == 0) readout_last = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (busy && i < 3000) begin
            tick();
            i++;
        end
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic send_cmd(input int n, input int cyc);
        cur_cyc   = cyc;
        cmd_data  = {W'(n), W'(cyc)};
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d ticks expected completion", tick_n);
        $fatal(1, "bench timeout");
    end

    initial begin
        int i;
        vecs[0] = '{n: 2, cyc: 10, dly: 5, exp_done: 2};
        vecs[1] = '{n: 1, cyc: 0,  dly: 5, exp_done: 1};
        vecs[2] = '{n: 3, cyc: 1,  dly: 3, exp_done: 3};
        vecs[3] = '{n: 1, cyc: 5,  dly: 2, exp_done: 1};
        vecs[4] = '{n: 0, cyc: 7,  dly: 5, exp_done: 0};

        repeat (2) @(posedge ps_clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {sw_reset_valid, ass_valid, readout_start_valid}, 0);
        chk("rst_ass_data", ass_data, 0);
        chk("rst_done", captures_done, 0);
        chk("rst_error", error, 0);
        ps_reset = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            depth_dly = vecs[v].dly;
            last_dly  = vecs[v].dly;
            for (int k = 0; k < vecs[v].n; k++) push_iter(vecs[v].cyc);
            send_cmd(vecs[v].n, vecs[v].cyc);
            chk("busy_after_cmd", busy, (vecs[v].n != 0));
            wait_idle("table");
            chk("table_done", captures_done, vecs[v].exp_done);
            chk("table_error", error, 0);
            chk("table_cmd_ready", cmd_ready, 1);
            chk("table_queue", exp_q.size(), 0);
        end

        // stop write stalled by ass_ready low for 7 cycles
        stop_gap_chk = 1'b0;
        push_iter(4);
        send_cmd(1, 4);
        i = 0;
        while (!(ass_valid && ass_data == 3'b001) && i < 200) begin
            tick();
            i++;
        end
        ass_ready = 1'b0;
        chk("stall_reached", ass_valid, 1);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("stall_valid", ass_valid, 1);
            chk("stall_data", ass_data, 3'b001);
        end
        ass_ready = 1'b1;
        wait_idle("stall");
        chk("stall_done", captures_done, 1);
        chk("stall_queue", exp_q.size(), 0);
        stop_gap_chk = 1'b1;

        // depth never arrives: timeout, error, one sw-reset, idle
        depth_dly = 0;
        last_dly  = 0;
        exp_q = '{0, 1, 2, 3, 0};
        send_cmd(1, 3);
        i = 0;
        while (!error && i < 300) begin
            tick();
            i++;
        end
        chk("tmo_error", error, 1);
        chk("tmo_latency", tick_n - t_stop, TMO + 1);
        wait_idle("tmo");
        chk("tmo_sticky", error, 1);
        chk("tmo_done", captures_done, 0);
        chk("tmo_queue", exp_q.size(), 0);
        depth_dly = 5;
        last_dly  = 5;
        push_iter(0);
        send_cmd(1, 0);
        chk("err_cleared", error, 0);
        wait_idle("after_tmo");
        chk("after_tmo_done", captures_done, 1);
        chk("after_tmo_queue", exp_q.size(), 0);

        // abort during CAPTURE: no stop, one sw-reset
        exp_q = '{0, 1, 2, 0};
        t_start = -1;
        send_cmd(2, 20);
        i = 0;
        while (t_start < 0 && i < 200) begin
            tick();
            i++;
        end
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_swrst", sw_reset_valid, 1);
        wait_idle("abort_cap");
        chk("abort_cap_done", captures_done, 0);
        chk("abort_cap_queue", exp_q.size(), 0);

        // abort while arm write pending: arm completes, then sw-reset
        exp_q = '{0, 1, 0};
        ass_ready = 1'b0;
        send_cmd(1, 5);
        i = 0;
        while (!ass_valid && i < 200) begin
            tick();
            i++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();
        chk("pend_valid_held", ass_valid, 1);
        chk("pend_data_held", ass_data, 3'b100);
        ass_ready = 1'b1;
        wait_idle("abort_pend");
        chk("abort_pend_queue", exp_q.size(), 0);

        // asynchronous reset while in READOUT
        depth_dly = 5;
        last_dly  = 0;
        push_iter(2);
        t_rs = -1;
        send_cmd(1, 2);
        i = 0;
        while (t_rs < 0 && i < 200) begin
            tick();
            i++;
        end
        repeat (2) tick();
        chk("pre_rst_busy", busy, 1);
        ps_reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_valids", {sw_reset_valid, ass_valid, readout_start_valid}, 0);
        chk("arst_ass_data", ass_data, 0);
        chk("arst_error", error, 0);
        tick();
        ps_reset = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
